rng_bounded_sampler: RTL and testbench

//  Downstream consumer of the mt19937 raw 32-bit stream. Maps each raw word to an unbiased

---
 rtl/rng_bounded_sampler.sv | 200 ++++++++++++++++++++
 tb/tb_rng_bounded_sampler.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_bounded_sampler.sv
// Bounded sampler for a raw 32-bit RNG stream: Lemire multiply-shift with rejection, FIFO output.
// Optional reject statistics are built when RNG_SAMPLER_STATS_EN is defined.
module rng_bounded_sampler #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          rnd_in,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    input  logic [31:0]          bound,
    input  logic                 bound_load,
    output logic                 busy,
    output logic [31:0]          out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] reject_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC_T,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic [31:0] bound_q;
    logic [31:0] thresh_q;
    logic [31:0] div_rem_q;
    logic [31:0] div_dvd_q;
    logic [4:0]  div_cnt_q;
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_next;
    logic        calc_done;

    logic        s1_valid_q;
    logic [63:0] s1_prod_q;
    logic [31:0] s1_raw_q;
    logic        bound_zero;
    logic        s1_reject;
    logic        push;
    logic [31:0] push_data;
    logic        accept;

    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] count_q;
    logic [OCC_W-1:0] occupancy;
    logic             room;
    logic             full;
    logic             pop;
    logic             push_ok;

    // Restoring divide step: shift in the next dividend bit, subtract the bound when it fits.
    // The remainder after 32 steps is (2^32 - bound) mod bound.
    assign rem_shift = {div_rem_q, div_dvd_q[31]};
    assign rem_ge    = rem_shift >= {1'b0, bound_q};
    assign rem_next  = rem_ge ? (rem_shift[31:0] - bound_q) : rem_shift[31:0];
    assign calc_done = (state_q == CALC_T) && (div_cnt_q == 5'd31);

    assign occupancy = count_q + OCC_W'(s1_valid_q);
    assign room      = occupancy < DEPTH_OCC;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        rnd_ready = 1'b0;
        case (state_q)
            IDLE: ;
            CALC_T: begin
                busy = 1'b1;
                if (calc_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                rnd_ready = room;
            end
            default: state_d = IDLE;
        endcase
        if (bound_load) begin
            state_d   = CALC_T;
            rnd_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bound_q   <= '0;
            thresh_q  <= '0;
            div_rem_q <= '0;
            div_dvd_q <= '0;
            div_cnt_q <= '0;
        end else if (bound_load) begin
            bound_q   <= bound;
            div_rem_q <= '0;
            div_dvd_q <= 32'd0 - bound;
            div_cnt_q <= '0;
        end else if (state_q == CALC_T) begin
            div_rem_q <= rem_next;
            div_dvd_q <= div_dvd_q << 1;
            div_cnt_q <= div_cnt_q + 5'd1;
            if (calc_done) begin
                thresh_q <= (bound_q == 32'd0) ? 32'd0 : rem_next;
            end
        end
    end

    assign accept = rnd_valid && rnd_ready;

    always_ff @(posedge clk) begin
        if (rst || bound_load) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= accept;
        end
    end

    // Payload registers are qualified by s1_valid_q, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_prod_q <= 64'(rnd_in) * 64'(bound_q);
            s1_raw_q  <= rnd_in;
        end
    end

    assign bound_zero = (bound_q == 32'd0);
    assign s1_reject  = s1_valid_q && !bound_zero && (s1_prod_q[31:0] < thresh_q);
    assign push       = s1_valid_q && !s1_reject;
    assign push_data  = bound_zero ? s1_raw_q : s1_prod_q[63:32];

    assign out_valid = (count_q != '0);
    assign full      = (count_q == DEPTH_OCC);
    assign pop       = out_valid && out_ready;
    assign push_ok   = push && (!full || pop);
    assign out_data  = mem[rd_ptr_q];

    // NOTE: the FIFO storage is reset because out_data reads it directly and must be 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (bound_load) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr_q] <= push_data;
                wr_ptr_q      <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                count_q <= count_q + OCC_W'(1);
            end else if (pop && !push_ok) begin
                count_q <= count_q - OCC_W'(1);
            end
        end
    end

`ifdef RNG_SAMPLER_STATS_EN
    logic [CNT_WIDTH-1:0] reject_q;

    always_ff @(posedge clk) begin
        if (rst || bound_load) begin
            reject_q <= '0;
        end else if (s1_reject && (reject_q != '1)) begin
            reject_q <= reject_q + 1'b1;
        end
    end

    assign reject_count = reject_q;
`else
    assign reject_count = '0;
`endif

endmodule

// File: tb/tb_rng_bounded_sampler.sv
// Self-checking bench for rng_bounded_sampler: directed cases with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_rng_bounded_sampler;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      rnd_in;
    logic             rnd_valid;
    logic             rnd_ready;
    logic [31:0]      bound;
    logic             bound_load;
    logic             busy;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] reject_count;

    int errors = 0;
    int checks = 0;

    rng_bounded_sampler #(
        .FIFO_DEPTH(DEPTH),
        .CNT_WIDTH (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rnd_in      (rnd_in),
        .rnd_valid   (rnd_valid),
        .rnd_ready   (rnd_ready),
        .bound       (bound),
        .bound_load  (bound_load),
        .busy        (busy),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .reject_count(reject_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Threshold straight from the definition: (2^32 - b) mod b, with b = 0 meaning no rejection.
    function automatic logic [31:0] ref_thresh(input logic [31:0] b);
        logic [63:0] span;
        if (b == 32'd0) return 32'd0;
        span = 64'h1_0000_0000 - 64'(b);
        return 32'(span % 64'(b));
    endfunction

    // Returns {keep, value} for one raw word under bound b.
    function automatic logic [32:0] ref_sample(input logic [31:0] b, input logic [31:0] w);
        logic [63:0] m;
        if (b == 32'd0) return {1'b1, w};
        m = 64'(w) * 64'(b);
        if (m[31:0] < ref_thresh(b)) return {1'b0, 32'd0};
        return {1'b1, m[63:32]};
    endfunction

    function automatic logic [31:0] pick_bound();
        case ($urandom_range(7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'd2;
            3: return 32'd3;
            4: return 32'd10;
            5: return 32'h8000_0000;
            6: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] exp_rejects(input int n);
`ifdef RNG_SAMPLER_STATS_EN
        return 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    // Transaction-level model: mode, words in flight and the queue of samples owed to the consumer.
    initial begin : scoreboard
        int          mode;
        int          calc_left;
        logic [31:0] mb;
        logic        have_flight;
        logic [31:0] flight;
        logic [31:0] q[$];
        int          rej;
        bit          live;
        logic        ready_e;
        logic [32:0] r;
        live = 0;
        mode = 0;
        calc_left = 0;
        mb = '0;
        have_flight = 0;
        flight = '0;
        rej = 0;
        forever begin
            @(negedge clk);
            if (live) begin
                ready_e = (mode == 2) && !bound_load && (q.size() + int'(have_flight) < DEPTH);
                check("busy", busy, mode == 1);
                check("rnd_ready", rnd_ready, ready_e);
                check("out_valid", out_valid, q.size() > 0);
                if (q.size() > 0) check("out_data", out_data, q[0]);
                check("reject_count", reject_count, exp_rejects(rej));
            end
            @(posedge clk);
            ready_e = (mode == 2) && !bound_load && (q.size() + int'(have_flight) < DEPTH);
            if (rst) begin
                live = 1;
                mode = 0;
                q.delete();
                have_flight = 0;
                rej = 0;
            end else if (live) begin
                if (bound_load) begin
                    mb = bound;
                    mode = 1;
                    calc_left = 32;
                    q.delete();
                    have_flight = 0;
                    rej = 0;
                end else begin
                    if (q.size() > 0 && out_ready) void'(q.pop_front());
                    if (have_flight) begin
                        r = ref_sample(mb, flight);
                        if (r[32]) q.push_back(r[31:0]);
                        else if (rej < CNT_MAX) rej++;
                    end
                    have_flight = ready_e && rnd_valid;
                    flight = rnd_in;
                    if (mode == 1) begin
                        calc_left--;
                        if (calc_left == 0) mode = 2;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] b);
        bound = b;
        bound_load = 1'b1;
        tick();
        bound_load = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic send_expect(input string tag, input logic [31:0] w, input logic keep,
                               input logic [31:0] val);
        rnd_in = w;
        rnd_valid = 1'b1;
        tick();
        rnd_valid = 1'b0;
        check({tag, "_not_yet"}, out_valid, 1'b0);
        tick();
        check({tag, "_valid"}, out_valid, keep);
        if (keep) check({tag, "_data"}, out_data, val);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          n;
        logic [31:0] acc[$];
        logic [31:0] w;
        logic [32:0] r;
        rst = 1'b1;
        rnd_valid = 1'b0;
        rnd_in = '0;
        bound = '0;
        bound_load = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_rnd_ready", rnd_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_reject_count", reject_count, 0);
        rst = 1'b0;
        tick();

        // Hand-computed pins for the model itself.
        check("model_t10", ref_thresh(32'd10), 32'd6);
        check("model_t3", ref_thresh(32'd3), 32'd1);
        check("model_b10_ff", ref_sample(32'd10, 32'hFFFF_FFFF), {1'b1, 32'd9});
        check("model_b10_rej", ref_sample(32'd10, 32'h1999_999A), {1'b0, 32'd0});

        do_load(32'd10);
        check("load_busy", busy, 1'b1);
        wait_idle(n);
        check("calc_cycles", n, 32);
        check("run_ready", rnd_ready, 1'b1);
        send_expect("b10_ff", 32'hFFFF_FFFF, 1'b1, 32'd9);
        send_expect("b10_8001", 32'h8000_0001, 1'b1, 32'd5);
        send_expect("b10_rej", 32'h1999_999A, 1'b0, 32'd0);
        check("b10_rej_count", reject_count, exp_rejects(1));

        do_load(32'd3);
        check("b3_cleared", reject_count, 0);
        wait_idle(n);
        send_expect("b3_zero", 32'd0, 1'b0, 32'd0);
        check("b3_rej_count", reject_count, exp_rejects(1));
        send_expect("b3_ff", 32'hFFFF_FFFF, 1'b1, 32'd2);

        do_load(32'd0);
        wait_idle(n);
        check("b0_calc_cycles", n, 32);
        send_expect("b0_pass", 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);

        do_load(32'd1);
        wait_idle(n);
        send_expect("b1_zero", $urandom, 1'b1, 32'd0);

        // Back-pressure: consumer stalled, producer always valid.
        do_load(32'd10);
        wait_idle(n);
        out_ready = 1'b0;
        rnd_valid = 1'b1;
        acc.delete();
        for (int i = 0; i < 10; i++) begin
            w = 32'h0C00_0000 + 32'(i) * 32'h1300_0000;
            rnd_in = w;
            #1;
            if (rnd_ready) acc.push_back(w);
            tick();
        end
        check("bp_accepts", acc.size(), 4);
        check("bp_ready_low", rnd_ready, 1'b0);
        rnd_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_valid", out_valid, 1'b1);
            if (i < acc.size()) begin
                r = ref_sample(32'd10, acc[i]);
                check("drain_data", out_data, r[31:0]);
            end
            tick();
        end
        check("drain_empty", out_valid, 1'b0);
        check("drain_ready_back", rnd_ready, 1'b1);

        // Reload while the FIFO is loaded and stage 1 holds a word.
        send_expect("pre_rej", 32'h1999_999A, 1'b0, 32'd0);
        check("pre_rej_count", reject_count, exp_rejects(1));
        out_ready = 1'b0;
        rnd_valid = 1'b1;
        repeat (4) begin
            rnd_in = $urandom | 32'h8000_0000;
            tick();
        end
        bound = 32'd7;
        bound_load = 1'b1;
        #1;
        check("load_ready_low", rnd_ready, 1'b0);
        tick();
        bound_load = 1'b0;
        rnd_valid = 1'b0;
        out_ready = 1'b1;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_busy", busy, 1'b1);
        check("flush_reject_count", reject_count, 0);

        // Reset in the middle of the threshold computation.
        repeat (10) tick();
        check("mid_calc_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_ready", rnd_ready, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_count", reject_count, 0);

        // Randomized traffic, checked every cycle by the scoreboard.
        do_load(pick_bound());
        for (int c = 0; c < 4000; c++) begin
            rnd_valid = ($urandom_range(3) != 0);
            case ($urandom_range(3))
                0: rnd_in = $urandom_range(15);
                1: rnd_in = 32'hFFFF_FFFF - $urandom_range(15);
                default: rnd_in = $urandom;
            endcase
            out_ready = ((c / 200) % 2 == 1) ? ($urandom_range(3) != 0) : ($urandom_range(4) == 0);
            bound_load = ($urandom_range(150) == 0);
            if (bound_load) bound = pick_bound();
            rst = ($urandom_range(2000) == 0);
            tick();
        end
        rst = 1'b0;
        bound_load = 1'b0;
        rnd_valid = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
